aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 decryption core. It is the inverse counterpart of the pipelined AES_top encryptor: it takes a 128-bit ciphertext and the cipher key, and returns the plaintext. It uses one inverse round per clock and an on-the-fly key schedule: the key is first expanded forward to round key 10, then walked backwards. A start/busy/done handshake lets a host feed AES_top ciphertext back in for round-trip checking.

---
 rtl/aes_pkg.sv | 116 +++++++++++
 rtl/aes_inv_cipher_iter_if.sv | 24 ++
 rtl/aes_inv_round.sv | 27 ++
 rtl/aes_inv_cipher_iter.sv | 91 +++++++++
 tb/tb_aes_inv_cipher_iter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, rcon, key-schedule steps and FSM encoding.
// The S-boxes are computed (GF inverse + affine map) instead of tabulated.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_ADDK  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] a); return gf_mul(a, 8'h09); endfunction
    function automatic logic [7:0] mul0b(input logic [7:0] a); return gf_mul(a, 8'h0b); endfunction
    function automatic logic [7:0] mul0d(input logic [7:0] a); return gf_mul(a, 8'h0d); endfunction
    function automatic logic [7:0] mul0e(input logic [7:0] a); return gf_mul(a, 8'h0e); endfunction

    // a^254 is the multiplicative inverse; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undoes key_fwd: the XOR chain is peeled from the last word back to the first.
    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = rk[31:0] ^ rk[63:32];
        n2 = rk[63:32] ^ rk[95:64];
        n1 = rk[95:64] ^ rk[127:96];
        n0 = rk[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Host-side bundle of the decryptor: start/busy/done handshake, operands, result and FSM state.
// start is sampled only while idle; busy spans accept..complete edge; done is a one-cycle result strobe.
interface aes_inv_cipher_iter_if;
    import aes_pkg::*;

    logic         start;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;
    state_t       fsm_state;

    modport master (
        output start, data_in, key,
        input  busy, done, plaintext, fsm_state
    );

    modport slave (
        input  start, data_in, key,
        output busy, done, plaintext, fsm_state
    );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] sub;
    logic [127:0] added;
    logic [127:0] mixed;

    // Byte (r,c) sits at index 4c+r; row r is rotated right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sub[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
        end
        assign mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end

    assign added  = sub ^ rk;
    assign result = last ? added : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: expands the key forward to round key 10, then runs one inverse
// round per clock while walking the key schedule backwards.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_inv_cipher_iter_if.slave  bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t       st;
    logic [3:0]   cnt;
    logic [127:0] blk;
    logic [127:0] rk;
    logic         busy_q;
    logic         done_q;
    logic [127:0] pt_q;
    logic [127:0] round_out;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    aes_inv_round u_round (
        .state  (blk),
        .rk     (rk),
        .last   (st == ST_FINAL),
        .result (round_out)
    );

    // ADDK always steps from round key 10; in ROUND the counter names the key being left.
    assign rk_fwd = key_fwd(rk, rcon(cnt));
    assign rk_inv = key_inv(rk, rcon((st == ST_ADDK) ? LAST_RND : cnt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= ST_IDLE;
            cnt    <= 4'd0;
            blk    <= '0;
            rk     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.start) begin
                        blk    <= bus.data_in;
                        rk     <= bus.key;
                        cnt    <= 4'd1;
                        busy_q <= 1'b1;
                        st     <= ST_KEXP;
                    end
                end
                ST_KEXP: begin
                    rk  <= rk_fwd;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_RND) st <= ST_ADDK;
                end
                ST_ADDK: begin
                    blk <= blk ^ rk;
                    rk  <= rk_inv;
                    cnt <= LAST_RND - 4'd1;
                    st  <= ST_ROUND;
                end
                ST_ROUND: begin
                    blk <= round_out;
                    rk  <= rk_inv;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) st <= ST_FINAL;
                end
                ST_FINAL: begin
                    pt_q   <= round_out;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    st     <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.plaintext = pt_q;
    assign bus.fsm_state = st;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for the iterative AES-128 decryptor using known ciphertext/plaintext pairs.
module tb_aes_inv_cipher_iter;
    import aes_pkg::*;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CT2  = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] PT2  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic reset;

    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            check("done_busy_excl", 128'(bus.busy), 128'(0));
            if (exp_q.size() == 0) begin
                check("spurious_done", 128'(bus.done), 128'(0));
            end else begin
                check("plaintext", bus.plaintext, exp_q.pop_front());
            end
        end
    end

    // drivers: called at a falling edge, return one falling edge after the accepting edge
    task automatic start_block(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
        bus.data_in = ct;
        bus.key     = k;
        bus.start   = 1'b1;
        exp_q.push_back(pt);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.key     = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Returns at the falling edge inside the done cycle; optionally pokes start for 3 cycles.
    task automatic wait_done(input string tag, input int poke_at);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (lat == poke_at) begin
                bus.start   = 1'b1;
                bus.data_in = CT2;
                bus.key     = KEY2;
            end
            if (lat == poke_at + 3) bus.start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(21));
        check({tag, "_busy_cycles"}, 128'(busy_cycles), 128'(21));
    endtask

    task automatic after_done(input string tag, input logic [127:0] pt);
        @(negedge clk);
        check({tag, "_done_width"}, 128'(bus.done), 128'(0));
        check({tag, "_pt_hold"}, bus.plaintext, pt);
        check({tag, "_idle"}, 128'(bus.fsm_state), 128'(ST_IDLE));
    endtask

    int dones_before;
    int busy_seen;

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.key     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_plaintext", bus.plaintext, 128'(0));
        check("rst_state", 128'(bus.fsm_state), 128'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 vector
        start_block(CT1, KEY1, PT1);
        check("v1_busy_at_accept", 128'(bus.busy), 128'(1));
        wait_done("v1", -10);
        after_done("v1", PT1);

        // second vector
        start_block(CT2, KEY2, PT2);
        wait_done("v2", -10);
        after_done("v2", PT2);

        // zero key, then restart in the done cycle
        start_block(CT0, 128'h0, 128'h0);
        wait_done("zero", -10);
        start_block(CT1, KEY1, PT1);
        check("b2b_busy", 128'(bus.busy), 128'(1));
        check("b2b_done_low", 128'(bus.done), 128'(0));
        wait_done("b2b", -10);
        after_done("b2b", PT1);

        // start while busy must be ignored
        dones_before = n_done;
        start_block(CT1, KEY1, PT1);
        wait_done("ignore", 5);
        busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_seen++;
        end
        check("ignore_busy_after", 128'(busy_seen), 128'(0));
        check("ignore_one_done", 128'(n_done - dones_before), 128'(1));
        check("ignore_pt", bus.plaintext, PT1);

        // reset mid-operation
        start_block(CT2, KEY2, PT2);
        repeat (12) @(negedge clk);
        check("abort_busy_before", 128'(bus.busy), 128'(1));
        reset = 1'b1;
        #1;
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_plaintext", bus.plaintext, 128'(0));
        check("abort_state", 128'(bus.fsm_state), 128'(ST_IDLE));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_block(CT1, KEY1, PT1);
        wait_done("post_abort", -10);
        after_done("post_abort", PT1);

        // loopback of encryptor outputs for both vectors
        start_block(CT1, KEY1, PT1);
        wait_done("loop1", -10);
        after_done("loop1", PT1);
        start_block(CT2, KEY2, PT2);
        wait_done("loop2", -10);
        after_done("loop2", PT2);

        repeat (3) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
